// File: rtl/mnist_nn_debug_ocimem_pkg.sv
// Shared definitions for the OCI debug monitor memory block.
//   - ocimem_state_e : arbitration FSM states
//   - JDO_*          : bit positions of fields inside the 38-bit JTAG data word
package mnist_nn_debug_ocimem_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StJRd,
        StJRdCap,
        StJWr,
        StCRd,
        StCRdCap,
        StCDone
    } ocimem_state_e;

    localparam int unsigned JDO_W          = 38;
    localparam int unsigned JDO_RD_BIT     = 35;
    localparam int unsigned JDO_ERRCLR_BIT = 36;
    localparam int unsigned JDO_ADDR_LSB   = 17;
    localparam int unsigned JDO_DATA_MSB   = 34;
    localparam int unsigned JDO_DATA_LSB   = 3;

endpackage

// File: rtl/mnist_nn_debug_ocimem_ram.sv
// Single-port debug monitor RAM, 32-bit words, 4 byte lanes, registered read.
//   clk   : clock
//   addr  : word address
//   we    : write enable (qualified by be)
//   be    : byte-lane enables
//   wdata : write data
//   rdata : read data, valid one cycle after addr is presented (read-before-write)
// INIT_HEX names the device-programming init image; empty leaves contents undefined.
module mnist_nn_debug_ocimem_ram #(
    parameter int unsigned ADDR_W   = 8,
    parameter string       INIT_HEX = ""
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    (* ram_init_file = INIT_HEX *) logic [31:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mnist_nn_debug_ocimem.sv
// OCI debug monitor memory: owns the monitor RAM and the MonDReg / monitor_ready /
// monitor_error status returned to the TCK side, and arbitrates the single RAM port
// between JTAG monitor commands and the CPU Avalon-MM debug slave.
//   clk, reset_n                : clock, synchronous active-low reset
//   jdo, take_*_ocimem_*        : JTAG command data and one-cycle command strobes
//   avs_*                       : CPU Avalon-MM slave (waitrequest-based)
//   MonDReg                     : monitor data register
//   monitor_ready, monitor_error: JTAG command complete / sticky error
module mnist_nn_debug_ocimem
    import mnist_nn_debug_ocimem_pkg::*;
#(
    parameter int unsigned ADDR_W   = 8,
    parameter string       INIT_HEX = ""
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic [3:0]        avs_byteenable,
    input  logic              avs_chipselect,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic              avs_debugaccess,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    ocimem_state_e     state_q;
    logic [ADDR_W-1:0] mon_areg_q;
    logic              jtag_rd_q;
    logic              jtag_wr_q;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [3:0]        ram_be;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    logic              cpu_req;
    logic              any_strobe;
    logic              cpu_accept;

    // Bits of jdo not carried by any command field.
    logic unused_jdo;
    assign unused_jdo = ^{jdo[JDO_W-1], jdo[JDO_DATA_LSB-1:0]};

    assign cpu_req    = avs_chipselect & (avs_read | avs_write);
    assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    // A strobe in the same cycle holds the CPU off so JTAG wins the conflict.
    assign cpu_accept = (state_q == StIdle) & ~jtag_wr_q & ~jtag_rd_q & ~any_strobe & cpu_req;

    // RAM port steering; writes are suppressed while reset is asserted.
    always_comb begin
        ram_addr  = mon_areg_q;
        ram_we    = 1'b0;
        ram_be    = 4'hF;
        ram_wdata = MonDReg;
        unique case (state_q)
            StJWr: ram_we = reset_n;
            StCRd: ram_addr = avs_address;
            StIdle: begin
                if (cpu_accept && avs_write) begin
                    ram_addr  = avs_address;
                    ram_be    = avs_byteenable;
                    ram_wdata = avs_writedata;
                    ram_we    = reset_n & avs_debugaccess;
                end
            end
            default: ;
        endcase
    end

    mnist_nn_debug_ocimem_ram #(
        .ADDR_W   (ADDR_W),
        .INIT_HEX (INIT_HEX)
    ) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .be    (ram_be),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= StIdle;
            mon_areg_q      <= '0;
            jtag_rd_q       <= 1'b0;
            jtag_wr_q       <= 1'b0;
            MonDReg         <= '0;
            monitor_ready   <= 1'b0;
            monitor_error   <= 1'b0;
            avs_readdata    <= '0;
            avs_waitrequest <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (jtag_wr_q) begin
                        state_q <= StJWr;
                    end else if (jtag_rd_q) begin
                        state_q <= StJRd;
                    end else if (cpu_accept) begin
                        if (avs_read) begin
                            state_q <= StCRd;
                        end else begin
                            state_q         <= StCDone;
                            avs_waitrequest <= 1'b0;
                            if (!avs_debugaccess) begin
                                monitor_error <= 1'b1;
                            end
                        end
                    end
                end
                StJWr: begin
                    mon_areg_q    <= mon_areg_q + 1'b1;
                    jtag_wr_q     <= 1'b0;
                    monitor_ready <= 1'b1;
                    state_q       <= StIdle;
                end
                StJRd: state_q <= StJRdCap;
                StJRdCap: begin
                    MonDReg       <= ram_rdata;
                    jtag_rd_q     <= 1'b0;
                    monitor_ready <= 1'b1;
                    state_q       <= StIdle;
                end
                StCRd: state_q <= StCRdCap;
                StCRdCap: begin
                    avs_readdata    <= ram_rdata;
                    avs_waitrequest <= 1'b0;
                    state_q         <= StCDone;
                end
                StCDone: begin
                    avs_waitrequest <= 1'b1;
                    state_q         <= StIdle;
                end
                default: state_q <= StIdle;
            endcase

            // Command decode comes last so a strobe overrides the FSM's own updates
            // and any pending JTAG op picks up the new register values.
            if (take_action_ocimem_a) begin
                mon_areg_q    <= jdo[JDO_ADDR_LSB +: ADDR_W];
                jtag_rd_q     <= jdo[JDO_RD_BIT];
                monitor_ready <= 1'b0;
                if (jdo[JDO_ERRCLR_BIT]) begin
                    monitor_error <= 1'b0;
                end
            end
            if (take_no_action_ocimem_a && jdo[JDO_RD_BIT]) begin
                mon_areg_q    <= mon_areg_q + 1'b1;
                jtag_rd_q     <= 1'b1;
                monitor_ready <= 1'b0;
            end
            if (take_action_ocimem_b) begin
                MonDReg       <= jdo[JDO_DATA_MSB:JDO_DATA_LSB];
                jtag_wr_q     <= 1'b1;
                monitor_ready <= 1'b0;
            end
        end
    end

endmodule
